// File: rtl/sr_cmd_pkg.sv
// ---------------------------------------------------------------------------
// sr_cmd_pkg : shared state/command types and request decode for the SR sequencer
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sr_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP = 2'd0,
    CMD_SET = 2'd1,
    CMD_CLR = 2'd2
  } cmd_t;

  // pol selects the winner when both requests are raised: 1 = set, 0 = clear
  function automatic cmd_t decode_cmd(input logic set, input logic clr, input logic pol);
    if (set && clr) return pol ? CMD_SET : CMD_CLR;
    else if (set)   return CMD_SET;
    else if (clr)   return CMD_CLR;
    else            return CMD_NOP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_cmd_timer.sv
// ---------------------------------------------------------------------------
// sr_cmd_timer : loadable down-counter with zero flag, holds at zero
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sr_cmd_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_count <= '0;
    else if (load)            r_count <= load_val;
    else if (r_count != '0)   r_count <= r_count - 1'b1;
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/sr_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// sr_cmd_sequencer : valid/ready set/clear requests -> timed, non-overlapping s/r pulses
// Optional macro   : SR_CMD_FILTER_EN (drop commands that would not change shadow_q)
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sr_cmd_sequencer #(
  parameter int HOLD_CYC     = 2,
  parameter int GAP_CYC      = 1,
  parameter int CONFLICT_POL = 0,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_set,
  input  logic             req_clr,
  output logic             req_ready,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             cmd_done,
  output logic             shadow_q,
  output logic [CNT_W-1:0] conflict_cnt
);

  import sr_cmd_pkg::*;

  localparam int TMAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] GAP_LD  = (GAP_CYC > 0) ? TW'(GAP_CYC - 1) : '0;

  state_t        r_state;
  cmd_t          r_cmd;
  cmd_t          w_dec;
  cmd_t          w_cmd;
  logic          w_accept;
  logic          w_conflict;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_zero;

  assign w_accept   = req_valid & req_ready;
  assign w_conflict = req_set & req_clr;
  assign w_dec      = decode_cmd(req_set, req_clr, CONFLICT_POL != 0);

`ifdef SR_CMD_FILTER_EN
  assign w_cmd = ((w_dec == CMD_SET && shadow_q) || (w_dec == CMD_CLR && !shadow_q))
                 ? CMD_NOP : w_dec;
`else
  assign w_cmd = w_dec;
`endif

  always_comb begin
    w_load     = 1'b0;
    w_load_val = HOLD_LD;
    if (r_state == ST_IDLE && w_accept && w_cmd != CMD_NOP) begin
      w_load = 1'b1;
    end else if (r_state == ST_DRIVE && w_zero && GAP_CYC > 0) begin
      w_load     = 1'b1;
      w_load_val = GAP_LD;
    end
  end

  sr_cmd_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_zero)
  );

  // s and r are only ever raised from IDLE on a decoded single command, so they cannot overlap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cmd     <= CMD_NOP;
      s         <= 1'b0;
      r         <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      cmd_done  <= 1'b0;
      shadow_q  <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_cmd == CMD_NOP) begin
              cmd_done <= 1'b1;
            end else begin
              r_state   <= ST_DRIVE;
              r_cmd     <= w_cmd;
              s         <= (w_cmd == CMD_SET);
              r         <= (w_cmd == CMD_CLR);
              req_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          if (w_zero) begin
            s        <= 1'b0;
            r        <= 1'b0;
            shadow_q <= (r_cmd == CMD_SET);
            if (GAP_CYC > 0) begin
              r_state <= ST_SETTLE;
            end else begin
              r_state   <= ST_IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
              cmd_done  <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (w_zero) begin
            r_state   <= ST_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            cmd_done  <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          s         <= 1'b0;
          r         <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (w_accept && w_conflict && conflict_cnt != '1) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sr_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sr_cmd_sequencer : directed + random checks of sr_cmd_sequencer against a timing model
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sr_cmd_sequencer;

  localparam int HOLD = 2;
  localparam int GAP  = 1;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_set = 1'b0;
  logic          req_clr = 1'b0;
  logic          req_ready, s, r, busy, cmd_done, shadow_q;
  logic [CW-1:0] conflict_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int m_shadow = 0;
  int m_cnt = 0;
  int last_acc = 0;

  sr_cmd_sequencer #(
    .HOLD_CYC(HOLD), .GAP_CYC(GAP), .CONFLICT_POL(0), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_set(req_set), .req_clr(req_clr),
    .req_ready(req_ready), .s(s), .r(r), .busy(busy), .cmd_done(cmd_done),
    .shadow_q(shadow_q), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      n_chk++;
      assert (!(s === 1'b1 && r === 1'b1))
        else begin n_err++; $error("FAIL sr_overlap: observed s=%0b r=%0b, expected not both 1", s, r); end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin n_err++; $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp); end
  endtask

  task automatic chk_all(input int es, input int er, input int eb, input int erdy,
                         input int edone, input int esh);
    chk("s", 32'(s), es);
    chk("r", 32'(r), er);
    chk("busy", 32'(busy), eb);
    chk("req_ready", 32'(req_ready), erdy);
    chk("cmd_done", 32'(cmd_done), edone);
    chk("shadow_q", 32'(shadow_q), esh);
    chk("conflict_cnt", 32'(conflict_cnt), m_cnt);
  endtask

  // Present one request, let it be accepted, then check every cycle until it completes.
  // kind: 0 = NOP, 1 = SET, 2 = CLR. exp_gap > 0 checks spacing from the previous accept.
  task automatic do_cmd(input logic vs, input logic vc, input logic nv, input logic ns,
                        input logic nc, input int exp_gap);
    int  kind, len, old_sh, new_sh, acc;
    int  es, er, eb, erdy, ed, esh;
    bit  ok;
    req_valid = 1'b1; req_set = vs; req_clr = vc;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept_wait", 32'(ok), 1);
    if (vs && vc) begin
      kind = 2;
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end else if (vs) kind = 1;
    else if (vc)     kind = 2;
    else             kind = 0;
`ifdef SR_CMD_FILTER_EN
    if ((kind == 1 && m_shadow == 1) || (kind == 2 && m_shadow == 0)) kind = 0;
`endif
    old_sh = m_shadow;
    new_sh = (kind == 1) ? 1 : (kind == 2) ? 0 : old_sh;
    len    = (kind == 0) ? 1 : HOLD + GAP + 1;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1) begin
        acc = cyc;
        if (exp_gap > 0) chk("accept_spacing", acc - last_acc, exp_gap);
        last_acc  = acc;
        req_valid = nv; req_set = ns; req_clr = nc;
      end
      if (kind == 0) begin
        es = 0; er = 0; eb = 0; erdy = 1; ed = 1; esh = old_sh;
      end else if (k <= HOLD) begin
        es = (kind == 1); er = (kind == 2); eb = 1; erdy = 0; ed = 0; esh = old_sh;
      end else if (k <= HOLD + GAP) begin
        es = 0; er = 0; eb = 1; erdy = 0; ed = 0; esh = new_sh;
      end else begin
        es = 0; er = 0; eb = 0; erdy = 1; ed = 1; esh = new_sh;
      end
      chk_all(es, er, eb, erdy, ed, esh);
    end
    m_shadow = new_sh;
  endtask

  initial begin
    logic [1:0] cur, nxt;
    bit         b2b;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_all(0, 0, 0, 1, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    do_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    do_cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    chk("conflict_one", 32'(conflict_cnt), 1);
    do_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    do_cmd(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    do_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, HOLD + GAP + 1);

    for (int i = 0; i < 300; i++)
      do_cmd(1'b1, 1'b1, (i < 299), 1'b1, 1'b1, -1);
    chk("conflict_sat", 32'(conflict_cnt), CMAX);

    cur = 2'($urandom_range(0, 3));
    for (int i = 0; i < 60; i++) begin
      nxt = 2'($urandom_range(0, 3));
      b2b = 1'($urandom_range(0, 1));
      do_cmd(cur[1], cur[0], b2b, b2b & nxt[1], b2b & nxt[0], -1);
      if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
      cur = nxt;
    end

    do_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    #2 rst = 1'b1;
    #1;
    m_shadow = 0; m_cnt = 0;
    chk_all(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    req_valid = 1'b1; req_set = 1'b1; req_clr = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_set = 1'b0;
    chk("abort_s_before", 32'(s), 1);
    #2 rst = 1'b1;
    #1;
    m_shadow = 0; m_cnt = 0;
    chk_all(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    do_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    do_cmd(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
